// File: rtl/uart_tx_arbiter.sv
// Three-requester round-robin arbiter that feeds one UART transmitter.
// Each winner gets one byte per frame; lock keeps priority for packets.
module uart_tx_arbiter #(
    parameter int BUSY_TO = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic       tx_busy,
    output logic [2:0] ack,
    output logic [2:0] grant,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       err_timeout
);

    localparam int CW = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [1:0]     ptr;
    logic [1:0]     ptr_nx;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nx;
    logic           tx_start_nx;
    logic [2:0]     ack_nx;
    logic [2:0]     grant_nx;
    logic [7:0]     tx_data_nx;
    logic           err_nx;

    logic [1:0]     ord1;
    logic [1:0]     ord2;
    logic           win_vld;
    logic [1:0]     win;
    logic [2:0]     win_oh;
    logic [7:0]     win_data;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign ord1 = inc3(ptr);
    assign ord2 = inc3(ord1);
    assign busy = (state != IDLE);

    // Winner search starting at ptr, wrapping modulo 3.
    always_comb begin
        win_vld = 1'b1;
        win     = ptr;
        if (req[ptr]) begin
            win = ptr;
        end else if (req[ord1]) begin
            win = ord1;
        end else if (req[ord2]) begin
            win = ord2;
        end else begin
            win_vld = 1'b0;
        end
    end

    // One-hot and data of the current winner.
    always_comb begin
        win_oh   = 3'b000;
        win_data = data2;
        case (win)
            2'd0: begin
                win_oh   = 3'b001;
                win_data = data0;
            end
            2'd1: begin
                win_oh   = 3'b010;
                win_data = data1;
            end
            default: begin
                win_oh   = 3'b100;
                win_data = data2;
            end
        endcase
    end

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        cnt_nx      = cnt;
        tx_start_nx = 1'b0;
        ack_nx      = 3'b000;
        grant_nx    = grant;
        tx_data_nx  = tx_data;
        err_nx      = err_timeout;
        case (state)
            IDLE: begin
                grant_nx = 3'b000;
                if (win_vld && !tx_busy) begin
                    state_nx    = WAIT_BUSY;
                    tx_start_nx = 1'b1;
                    ack_nx      = win_oh;
                    grant_nx    = win_oh;
                    tx_data_nx  = win_data;
                    cnt_nx      = '0;
                    ptr_nx      = lock[win] ? win : inc3(win);
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(BUSY_TO - 1)) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                    grant_nx = 3'b000;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx = IDLE;
                    grant_nx = 3'b000;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 3'b000;
                cnt_nx   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            cnt         <= '0;
            tx_start    <= 1'b0;
            ack         <= 3'b000;
            grant       <= 3'b000;
            tx_data     <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            tx_start    <= tx_start_nx;
            ack         <= ack_nx;
            grant       <= grant_nx;
            tx_data     <= tx_data_nx;
            err_timeout <= err_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model,
// emulated UART transmitter, directed scenarios and random traffic.
module tb_uart_tx_arbiter;

    localparam int BUSY_TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       tx_busy;
    logic [2:0] ack;
    logic [2:0] grant;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       err_timeout;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    // Reference model: who owns the line, whether the frame has begun,
    // how long we have waited, and the round-robin start point.
    int         m_owner;
    bit         m_seen;
    int         m_wait;
    int         m_rr;
    bit         m_start;
    logic [2:0] m_ack;
    logic [7:0] m_data;
    bit         m_err;
    bit         m_start_seen;

    // Emulated transmitter: 0 = never busy, 1 = normal, 2 = stuck busy.
    int tmode = 1;
    int frame_len = 5;
    int frame_left = 0;

    logic [7:0] sent[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.BUSY_TO(BUSY_TO)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .lock(lock),
        .data0(data0),
        .data1(data1),
        .data2(data2),
        .tx_busy(tx_busy),
        .ack(ack),
        .grant(grant),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] onehot(input int g);
        logic [2:0] r;
        r = 3'b000;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] offered(input int g);
        if (g == 0) return data0;
        if (g == 1) return data1;
        return data2;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_seen = 0;
        m_wait = 0;
        m_rr = 0;
        m_start = 0;
        m_ack = 3'b000;
        m_data = 8'h00;
        m_err = 0;
        m_start_seen = 0;
    endtask

    // Advance the model by one clock edge using the sampled inputs.
    task automatic model_step();
        int g;
        m_start_seen = m_start;
        m_start = 0;
        m_ack = 3'b000;
        if (m_owner < 0) begin
            if (req != 3'b000 && !tx_busy) begin
                g = -1;
                for (int k = 0; k < 3; k++)
                    if (g < 0 && req[(m_rr + k) % 3]) g = (m_rr + k) % 3;
                m_owner = g;
                m_seen = 0;
                m_wait = 0;
                m_start = 1;
                m_ack = onehot(g);
                m_data = offered(g);
                m_rr = lock[g] ? g : (g + 1) % 3;
            end
        end else if (!m_seen) begin
            if (tx_busy) begin
                m_seen = 1;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == BUSY_TO) begin
                    m_err = 1;
                    m_owner = -1;
                    m_wait = 0;
                end
            end
        end else if (!tx_busy) begin
            m_owner = -1;
        end
    endtask

    // One clock: model on the edge, transmitter reacts just after it.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        if (tmode == 0) begin
            tx_busy = 1'b0;
            frame_left = 0;
        end else if (tmode == 2) begin
            tx_busy = 1'b1;
        end else if (m_start_seen) begin
            tx_busy = 1'b1;
            frame_left = frame_len;
        end else if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) tx_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_owner >= 0 && n < 200) begin
            cycle();
            n++;
        end
        chk("idle_bound", busy, 0);
    endtask

    task automatic wait_sent(input int want);
        int n;
        n = 0;
        while (sent.size() < want && n < 400) begin
            cycle();
            n++;
        end
        chk("sent_bound", 32'(sent.size() >= want), 1);
    endtask

    // Compare the DUT with the model once per cycle, away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("grant", grant, onehot(m_owner));
                chk("ack", ack, m_ack);
                chk("tx_start", tx_start, m_start);
                chk("tx_data", tx_data, m_data);
                chk("busy", busy, m_owner >= 0);
                chk("err_timeout", err_timeout, m_err);
                if (tx_start === 1'b1) sent.push_back(tx_data);
            end
        end
    end

    initial begin
        int n;
        int wins2;
        rst = 1'b1;
        req = 3'b000;
        lock = 3'b000;
        data0 = 8'h00;
        data1 = 8'h00;
        data2 = 8'h00;
        tx_busy = 1'b0;
        model_reset();
        #2;
        chk("rst_grant", grant, 3'b000);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_err", err_timeout, 0);
        chk_en = 1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single byte from requester 1.
        sent.delete();
        req = 3'b010;
        data1 = 8'h41;
        cycle();
        chk("single_start", tx_start, 1);
        chk("single_data", tx_data, 8'h41);
        chk("single_ack", ack, 3'b010);
        chk("single_grant", grant, 3'b010);
        req = 3'b000;
        wait_idle();
        chk("single_count", sent.size(), 1);

        // Fairness: all three requesting, no lock.
        do_reset();
        sent.delete();
        req = 3'b111;
        data0 = 8'h61;
        data1 = 8'h62;
        data2 = 8'h63;
        wait_sent(4);
        req = 3'b000;
        wait_idle();
        if (sent.size() >= 4) begin
            chk("fair0", sent[0], 8'h61);
            chk("fair1", sent[1], 8'h62);
            chk("fair2", sent[2], 8'h63);
            chk("fair3", sent[3], 8'h61);
        end

        // Lock: requester 2 holds priority across a packet.
        do_reset();
        sent.delete();
        req = 3'b101;
        lock = 3'b100;
        data0 = 8'h30;
        data2 = 8'h32;
        wins2 = 0;
        n = 0;
        while (sent.size() < 5 && n < 400) begin
            cycle();
            n++;
            if (m_ack[2]) wins2++;
            if (wins2 >= 2) lock = 3'b000;
        end
        req = 3'b000;
        wait_idle();
        chk("lock_count", sent.size(), 5);
        if (sent.size() >= 5) begin
            chk("lock0", sent[0], 8'h30);
            chk("lock1", sent[1], 8'h32);
            chk("lock2", sent[2], 8'h32);
            chk("lock3", sent[3], 8'h32);
            chk("lock4", sent[4], 8'h30);
        end

        // Busy guard: transmitter already busy holds off the launch.
        do_reset();
        sent.delete();
        tmode = 2;
        tx_busy = 1'b1;
        req = 3'b001;
        repeat (8) cycle();
        chk("guard_none", sent.size(), 0);
        tmode = 1;
        tx_busy = 1'b0;
        frame_left = 0;
        cycle();
        chk("guard_start", tx_start, 1);
        req = 3'b000;
        wait_idle();

        // Timeout: transmitter never answers.
        do_reset();
        sent.delete();
        tmode = 0;
        req = 3'b001;
        data0 = 8'h77;
        repeat (4) cycle();
        chk("to_early", err_timeout, 0);
        chk("to_grant_held", grant, 3'b001);
        cycle();
        chk("to_err", err_timeout, 1);
        chk("to_grant", grant, 3'b000);
        cycle();
        chk("to_relaunch", tx_start, 1);
        req = 3'b000;
        tmode = 1;
        wait_idle();

        // Reset in the middle of a frame clears everything, ptr too.
        req = 3'b100;
        data2 = 8'h5a;
        n = 0;
        while (!(m_owner >= 0 && m_seen) && n < 100) begin
            cycle();
            n++;
        end
        chk("mid_reached", busy, 1);
        req = 3'b000;
        cycle();
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_grant", grant, 3'b000);
        chk("mid_ack", ack, 3'b000);
        chk("mid_start", tx_start, 0);
        chk("mid_data", tx_data, 8'h00);
        chk("mid_busy", busy, 0);
        chk("mid_err", err_timeout, 0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("mid_no_start", tx_start, 0);
        n = 0;
        while (tx_busy && n < 50) begin
            cycle();
            n++;
        end
        req = 3'b111;
        cycle();
        chk("mid_ptr0", ack, 3'b001);
        req = 3'b000;
        wait_idle();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            cycle();
            if (i % 250 == 0) tmode = ($urandom_range(0, 7) == 0) ? 0 : 1;
            frame_len = $urandom_range(1, 6);
            req = 3'($urandom);
            lock = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            data2 = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
        end
        rst = 1'b0;
        req = 3'b000;
        tmode = 1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
